// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - load / capture / unload controller for one scan chain
// Optional response signature LFSR enabled by defining SCAN_SIGNATURE_EN.

module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response,
    output logic [15:0]          signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] response_q, response_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_in_q, scan_in_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cnt_last;
    logic                 accept;
    logic                 unloading;

    assign cnt_last  = (cnt_q == CNT_LAST);
    assign accept    = (state_q == S_IDLE) && start;
    assign unloading = (state_q == S_SHIFT_OUT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            response_q <= '0;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            response_q <= response_d;
            scan_en_q  <= scan_en_d;
            scan_in_q  <= scan_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The counter clears on every phase exit so each shift phase runs 0..L-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT_IN;
                    cnt_d   = '0;
                end
            end
            S_SHIFT_IN: begin
                if (cnt_last) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: state_d = S_SHIFT_OUT;
            S_SHIFT_OUT: begin
                if (cnt_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state they describe without any input-to-output combinational path.
    always_comb begin
        pat_d      = pat_q;
        response_d = response_q;
        scan_in_d  = 1'b0;
        scan_en_d  = (state_d == S_SHIFT_IN) || (state_d == S_SHIFT_OUT);
        busy_d     = (state_d == S_SHIFT_IN) || (state_d == S_CAPTURE) ||
                     (state_d == S_SHIFT_OUT);
        done_d     = (state_d == S_DONE);
        if (accept) begin
            pat_d     = pattern >> 1;
            scan_in_d = pattern[0];
        end else if (state_q == S_SHIFT_IN) begin
            pat_d     = pat_q >> 1;
            scan_in_d = cnt_last ? 1'b0 : pat_q[0];
        end else if (unloading) begin
            response_d = {scan_out, response_q[CHAIN_LEN-1:1]};
        end
    end

    assign scan_en  = scan_en_q;
    assign scan_in  = scan_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = response_q;

`ifdef SCAN_SIGNATURE_EN
    logic [15:0] sig_q, sig_d;
    logic        sig_fb;

    assign sig_fb = sig_q[15] ^ scan_out;

    always_comb begin
        sig_d = sig_q;
        if (accept) begin
            sig_d = 16'hFFFF;
        end else if (unloading) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_q <= 16'hFFFF;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed and randomized bench for scan_chain_ctrl with a behavioural chain

module tb_scan_chain_ctrl;

    localparam int L = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [L-1:0] pattern = '0;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic         busy;
    logic         done;
    logic [L-1:0] response;
    logic [15:0]  signature;

    int total = 0;
    int bad   = 0;

    logic [L-1:0] chain  = '0;
    logic         invert = 1'b0;

    scan_chain_ctrl #(.CHAIN_LEN(L)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (scan_out),
        .busy     (busy),
        .done     (done),
        .response (response),
        .signature(signature)
    );

    always #5 clock = ~clock;

    // Cell 0 takes SI; in capture each cell loads SD = Q or ~Q.
    always @(posedge clock) begin
        if (scan_en) chain <= {chain[L-2:0], scan_in};
        else if (invert) chain <= ~chain;
    end
    assign scan_out = chain[L-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_sig(input logic [L-1:0] resp);
`ifdef SCAN_SIGNATURE_EN
        logic [15:0] s = 16'hFFFF;
        for (int i = 0; i < L; i++) begin
            if (s[15] ^ resp[i]) s = {s[14:0], 1'b0} ^ 16'h1021;
            else                 s = {s[14:0], 1'b0};
        end
        return s;
`else
        return resp[15:0] & 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] reset_sig();
`ifdef SCAN_SIGNATURE_EN
        return 16'hFFFF;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic run_test(input logic [L-1:0] pat, input logic inv,
                            input bit repulse, input int abort_at);
        logic [L-1:0] exp_resp;
        logic [L-1:0] other;
        exp_resp = inv ? ~pat : pat;
        other    = pat ^ 16'h5A5A;
        @(negedge clock);
        invert  = inv;
        pattern = pat;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        pattern = L'($urandom());
        for (int k = 1; k <= 2*L+2; k++) begin
            @(negedge clock);
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_scan_en", 32'(scan_en), 32'(0));
                check("abort_scan_in", 32'(scan_in), 32'(0));
                check("abort_busy", 32'(busy), 32'(0));
                check("abort_done", 32'(done), 32'(0));
                check("abort_response", 32'(response), 32'(0));
                check("abort_signature", 32'(signature), 32'(reset_sig()));
                @(negedge clock);
                reset = 1'b0;
                @(negedge clock);
                check("post_abort_done", 32'(done), 32'(0));
                return;
            end
            check("scan_en", 32'(scan_en), 32'((k <= L) || (k >= L+2 && k <= 2*L+1)));
            check("busy", 32'(busy), 32'(k <= 2*L+1));
            check("done", 32'(done), 32'(k == 2*L+2));
            if (k <= L) check("scan_in", 32'(scan_in), 32'(pat[k-1]));
            else if (k <= 2*L+1) check("scan_in_zero", 32'(scan_in), 32'(0));
            if (k == 2*L+2) begin
                check("response", 32'(response), 32'(exp_resp));
                check("signature", 32'(signature), 32'(ref_sig(exp_resp)));
            end
            if (repulse && (k == 5 || k == 2*L+2)) begin
                start   = 1'b1;
                pattern = other;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clock);
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));
        check("idle_scan_en", 32'(scan_en), 32'(0));
        check("idle_response", 32'(response), 32'(exp_resp));
        @(negedge clock);
        check("idle_busy2", 32'(busy), 32'(0));
    endtask

    initial begin
        #2;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_scan_en", 32'(scan_en), 32'(0));
        check("rst_scan_in", 32'(scan_in), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_response", 32'(response), 32'(0));
        check("rst_signature", 32'(signature), 32'(reset_sig()));
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_no_done", 32'(done), 32'(0));
            check("idle_no_busy", 32'(busy), 32'(0));
        end

        run_test(16'hA5C3, 1'b0, 1'b0, 0);
        run_test(16'h00FF, 1'b1, 1'b0, 0);
        run_test(16'h3C96, 1'b0, 1'b1, 0);
        run_test(L'($urandom()), 1'b0, 1'b0, 20);
        run_test(16'h1234, 1'b0, 1'b0, 0);
        run_test(16'h0000, 1'b0, 1'b0, 0);
        for (int r = 0; r < 6; r++) begin
            run_test(L'($urandom()), 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
